// File: rtl/mult_share_arbiter_pkg.sv
// mult_share_arbiter_pkg: FSM state encodings and default sizing for the shared multiplier arbiter
package mult_share_arbiter_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESPOND   = 3'd4
  } state_t;
  localparam int NREQ_D  = 4;
  localparam int WIDTH_D = 8;
endpackage

// File: rtl/mult_share_arbiter_rr_pick.sv
// rr_pick: round-robin selector, first set req at or after ptr wins
module rr_pick
  import mult_share_arbiter_pkg::*;
#(
  parameter  int NREQ = NREQ_D,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   idx,
  output logic            any
);
  int j;
  always_comb begin
    j   = 0;
    idx = '0;
    any = 1'b0;
    // walk the ring backwards so the candidate nearest ptr is assigned last
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) begin
        idx = IW'(j);
        any = 1'b1;
      end
    end
    win = any ? (NREQ'(1) << idx) : '0;
  end
endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: shares one sequential multiplier among NREQ clients
// with round-robin grants and a one-cycle done pulse per finished product
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int NREQ  = NREQ_D,
  parameter int WIDTH = WIDTH_D
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] op_a,
  input  logic [NREQ*WIDTH-1:0] op_b,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [2*WIDTH-1:0]    product,
  output logic                  mul_start,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  input  logic                  mul_stop,
  input  logic [2*WIDTH-1:0]    mul_product
);
  localparam int IW = $clog2(NREQ);
  state_t state;
  logic [IW-1:0] ptr, sel, idx;
  logic [NREQ-1:0] win;
  logic any;
  rr_pick #(.NREQ(NREQ)) u_pick (
    .req(req),
    .ptr(ptr),
    .win(win),
    .idx(idx),
    .any(any)
  );
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      ptr       <= '0;
      sel       <= '0;
      gnt       <= '0;
      done      <= '0;
      mul_start <= 1'b0;
      product   <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
    end else begin
      case (state)
        IDLE: if (any && mul_stop) begin
          mul_a     <= op_a[idx*WIDTH +: WIDTH];
          mul_b     <= op_b[idx*WIDTH +: WIDTH];
          gnt       <= win;
          sel       <= idx;
          mul_start <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: begin
          mul_start <= 1'b0;
          state     <= WAIT_BUSY;
        end
        WAIT_BUSY: if (!mul_stop) state <= WAIT_DONE;
        WAIT_DONE: if (mul_stop) begin
          product <= mul_product;
          done    <= gnt;
          state   <= RESPOND;
        end
        RESPOND: begin
          done  <= '0;
          gnt   <= '0;
          ptr   <= (sel == IW'(NREQ - 1)) ? '0 : sel + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
